// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the EX-stage forwarding/hazard control.
//   REG_AW  : register-index width
//   FWD_*   : encodings of the 3:1 ALU operand mux select
package cpu_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] FWD_RF  = 2'b00;  // operand straight from the register file
  localparam logic [1:0] FWD_WB  = 2'b01;  // operand from the MEM/WB register
  localparam logic [1:0] FWD_MEM = 2'b10;  // operand from the EX/MEM register

endpackage

// File: rtl/fwd_sel_cmp.sv
// fwd_sel_cmp: compare/priority logic for one ALU operand.
//   ex_v_i     : EX holds a real instruction
//   ex_src_i   : source register of this operand in EX
//   mem_*_i    : valid / regwrite / memread / rd of the MEM shadow stage
//   wb_*_i     : valid / regwrite / rd of the WB shadow stage
//   sel_o      : mux select (FWD_RF / FWD_WB / FWD_MEM)
module fwd_sel_cmp
  import cpu_pkg::*;
#(
  parameter int REG_AW = cpu_pkg::REG_AW
) (
  input  logic              ex_v_i,
  input  logic [REG_AW-1:0] ex_src_i,
  input  logic              mem_v_i,
  input  logic              mem_rw_i,
  input  logic              mem_mr_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              wb_v_i,
  input  logic              wb_rw_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  output logic [1:0]        sel_o
);

  logic w_mem_hit;
  logic w_wb_hit;

  // A load sitting in MEM has no data yet, so it is excluded from the MEM hit.
  assign w_mem_hit = mem_v_i && mem_rw_i && !mem_mr_i &&
                     (mem_rd_i != '0) && (mem_rd_i == ex_src_i);
  assign w_wb_hit  = wb_v_i && wb_rw_i &&
                     (wb_rd_i != '0) && (wb_rd_i == ex_src_i);

  // MEM is the younger producer, so it wins over WB.
  always_comb begin
    sel_o = FWD_RF;
    if (ex_v_i) begin
      if (w_mem_hit) begin
        sel_o = FWD_MEM;
      end else if (w_wb_hit) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: control side of the EX-stage operand forwarding muxes.
// Shadows the destination info of the EX, MEM and WB instructions, drives the
// operand A/B mux selects and raises a one-cycle stall on load-use hazards.
//   clk_i, rst_i                 : clock, synchronous active-high reset
//   id_valid_i                   : ID instruction is issuing this cycle
//   id_rs_i / id_rt_i / id_rd_i  : ID source A, source B, destination
//   id_regwrite_i, id_memread_i  : ID writes the register file / is a load
//   flush_i                      : kill the ID instruction
//   stall_o                      : load-use stall request
//   ex_valid_o                   : EX holds a real instruction
//   fwd_a_sel_o, fwd_b_sel_o     : operand mux selects
//   stall_cnt_o                  : saturating stall-cycle count
module fwd_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW = cpu_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      return c;
    end
    return c + 1'b1;
  endfunction

  logic              r_ex_v;
  logic [REG_AW-1:0] r_ex_rs;
  logic [REG_AW-1:0] r_ex_rt;
  logic [REG_AW-1:0] r_ex_rd;
  logic              r_ex_rw;
  logic              r_ex_mr;
  logic              r_mem_v;
  logic [REG_AW-1:0] r_mem_rd;
  logic              r_mem_rw;
  logic              r_mem_mr;
  logic              r_wb_v;
  logic [REG_AW-1:0] r_wb_rd;
  logic              r_wb_rw;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic w_stall;
  logic w_issue;

  // flush wins over stall: a flushed instruction never needs to wait.
  assign w_stall = id_valid_i && !flush_i && r_ex_v && r_ex_mr && (r_ex_rd != '0) &&
                   ((r_ex_rd == id_rs_i) || (r_ex_rd == id_rt_i));
  assign w_issue = id_valid_i && !flush_i && !w_stall;

  // ID -> EX -> MEM -> WB: valid bits and counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ex_v      <= 1'b0;
      r_mem_v     <= 1'b0;
      r_wb_v      <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_ex_v  <= w_issue;
      r_mem_v <= r_ex_v;
      r_wb_v  <= r_mem_v;
      if (w_stall) begin
        r_stall_cnt <= sat_inc(r_stall_cnt);
      end
    end
  end

  // ID -> EX -> MEM -> WB: register indices and flags, qualified by the valid bits
  always_ff @(posedge clk_i) begin
    r_ex_rs  <= id_rs_i;
    r_ex_rt  <= id_rt_i;
    r_ex_rd  <= id_rd_i;
    r_ex_rw  <= id_regwrite_i;
    r_ex_mr  <= id_memread_i;
    r_mem_rd <= r_ex_rd;
    r_mem_rw <= r_ex_rw;
    r_mem_mr <= r_ex_mr;
    r_wb_rd  <= r_mem_rd;
    r_wb_rw  <= r_mem_rw;
  end

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_sel_a (
    .ex_v_i   (r_ex_v),
    .ex_src_i (r_ex_rs),
    .mem_v_i  (r_mem_v),
    .mem_rw_i (r_mem_rw),
    .mem_mr_i (r_mem_mr),
    .mem_rd_i (r_mem_rd),
    .wb_v_i   (r_wb_v),
    .wb_rw_i  (r_wb_rw),
    .wb_rd_i  (r_wb_rd),
    .sel_o    (fwd_a_sel_o)
  );

  fwd_sel_cmp #(.REG_AW(REG_AW)) u_sel_b (
    .ex_v_i   (r_ex_v),
    .ex_src_i (r_ex_rt),
    .mem_v_i  (r_mem_v),
    .mem_rw_i (r_mem_rw),
    .mem_mr_i (r_mem_mr),
    .mem_rd_i (r_mem_rd),
    .wb_v_i   (r_wb_v),
    .wb_rw_i  (r_wb_rw),
    .wb_rd_i  (r_wb_rd),
    .sel_o    (fwd_b_sel_o)
  );

  assign stall_o     = w_stall;
  assign ex_valid_o  = r_ex_v;
  assign stall_cnt_o = r_stall_cnt;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  localparam int AW   = 5;
  localparam int CW   = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic [AW-1:0] id_rd;
  logic          id_rw;
  logic          id_mr;
  logic          flush;
  logic          stall;
  logic          ex_valid;
  logic [1:0]    sel_a;
  logic [1:0]    sel_b;
  logic [CW-1:0] scnt;

  fwd_hazard_ctrl #(.REG_AW(AW), .CNT_W(CW)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_rd_i       (id_rd),
    .id_regwrite_i (id_rw),
    .id_memread_i  (id_mr),
    .flush_i       (flush),
    .stall_o       (stall),
    .ex_valid_o    (ex_valid),
    .fwd_a_sel_o   (sel_a),
    .fwd_b_sel_o   (sel_b),
    .stall_cnt_o   (scnt)
  );

  // Reference model: one record per in-flight instruction slot.
  typedef struct {
    bit v;
    int rs;
    int rt;
    int rd;
    bit rw;
    bit mr;
  } ins_t;

  ins_t m_ex, m_mem, m_wb;
  int   m_cnt;
  int   total = 0;
  int   bad   = 0;
  bit   chk_en = 0;

  // Does slot s deliver a usable value for register r?
  function automatic bit delivers(ins_t s, int r, bit load_ok);
    return s.v && s.rw && (load_ok || !s.mr) && (r != 0) && (s.rd == r);
  endfunction

  function automatic int exp_sel(int r);
    if (!m_ex.v) return 0;
    if (delivers(m_mem, r, 1'b0)) return 2;
    if (delivers(m_wb, r, 1'b1)) return 1;
    return 0;
  endfunction

  // The ID instruction needs the result of the load now in EX.
  function automatic bit exp_stall();
    int rs, rt;
    rs = int'(id_rs);
    rt = int'(id_rt);
    if (!id_valid || flush) return 0;
    if (!(m_ex.v && m_ex.mr && m_ex.rd != 0)) return 0;
    return (m_ex.rd == rs) || (m_ex.rd == rt);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex.v  <= 0;
      m_mem.v <= 0;
      m_wb.v  <= 0;
      m_cnt   <= 0;
    end else begin
      if (exp_stall() && m_cnt < CMAX) m_cnt <= m_cnt + 1;
      m_wb     <= m_mem;
      m_mem    <= m_ex;
      m_ex.v   <= id_valid && !flush && !exp_stall();
      m_ex.rs  <= int'(id_rs);
      m_ex.rt  <= int'(id_rt);
      m_ex.rd  <= int'(id_rd);
      m_ex.rw  <= id_rw;
      m_ex.mr  <= id_mr;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, exp_stall());
      check("ex_valid", ex_valid, m_ex.v);
      check("sel_a", sel_a, exp_sel(m_ex.rs));
      check("sel_b", sel_b, exp_sel(m_ex.rt));
      check("stall_cnt", scnt, m_cnt);
    end
  end

  task automatic drive(input bit v, input int rs, input int rt, input int rd,
                       input bit rw, input bit mr, input bit fl);
    @(posedge clk);
    #1;
    id_valid = v;
    id_rs    = AW'(rs);
    id_rt    = AW'(rt);
    id_rd    = AW'(rd);
    id_rw    = rw;
    id_mr    = mr;
    flush    = fl;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  bit hold;

  initial begin
    rst = 1'b1; id_valid = 0; id_rs = '0; id_rt = '0; id_rd = '0;
    id_rw = 0; id_mr = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1;

    at_neg();
    check("rst_ex_valid", ex_valid, 0);
    check("rst_sel_a", sel_a, 0);
    check("rst_sel_b", sel_b, 0);
    check("rst_stall", stall, 0);
    check("rst_cnt", scnt, 0);

    // add r1 ; add r2,r1,r3
    drive(1, 2, 3, 1, 1, 0, 0);
    drive(1, 1, 3, 2, 1, 0, 0);
    nop();
    at_neg();
    check("t1_sel_a", sel_a, 2'b10);
    check("t1_sel_b", sel_b, 2'b00);
    check("t1_stall", stall, 0);

    // add r1 ; nop ; sub r5,r4,r1
    drive(1, 2, 3, 1, 1, 0, 0);
    nop();
    drive(1, 4, 1, 5, 1, 0, 0);
    nop();
    at_neg();
    check("t2_sel_a", sel_a, 2'b00);
    check("t2_sel_b", sel_b, 2'b01);

    // add r1 ; add r1 ; or r6,r1,r1
    drive(1, 2, 3, 1, 1, 0, 0);
    drive(1, 2, 3, 1, 1, 0, 0);
    drive(1, 1, 1, 6, 1, 0, 0);
    nop();
    at_neg();
    check("t3_sel_a", sel_a, 2'b10);
    check("t3_sel_b", sel_b, 2'b10);

    // lw r4 ; add r7,r2,r4 (held one cycle by the stall)
    drive(1, 2, 3, 4, 1, 1, 0);
    drive(1, 2, 4, 7, 1, 0, 0);
    at_neg();
    check("t4_stall", stall, 1);
    drive(1, 2, 4, 7, 1, 0, 0);
    at_neg();
    check("t4_bubble", ex_valid, 0);
    check("t4_stall_off", stall, 0);
    nop();
    at_neg();
    check("t4_ex_valid", ex_valid, 1);
    check("t4_sel_b", sel_b, 2'b01);
    check("t4_sel_a", sel_a, 2'b00);
    check("t4_cnt", scnt, 1);

    // r0 is never forwarded and never stalls
    drive(1, 1, 2, 0, 1, 0, 0);
    drive(1, 0, 0, 3, 1, 0, 0);
    at_neg();
    check("t5_stall_a", stall, 0);
    nop();
    at_neg();
    check("t5_sel_a", sel_a, 0);
    check("t5_sel_b", sel_b, 0);
    drive(1, 1, 2, 0, 1, 1, 0);
    drive(1, 0, 0, 3, 1, 0, 0);
    at_neg();
    check("t5_stall_b", stall, 0);
    nop();
    at_neg();
    check("t5_ex_valid", ex_valid, 1);
    check("t5_sel_a2", sel_a, 0);
    check("t5_sel_b2", sel_b, 0);

    // flush beats stall
    drive(1, 2, 3, 4, 1, 1, 0);
    drive(1, 4, 4, 7, 1, 0, 1);
    at_neg();
    check("t6_stall", stall, 0);
    nop();
    at_neg();
    check("t6_ex_valid", ex_valid, 0);
    check("t6_cnt", scnt, 1);

    // reset mid-stream
    drive(1, 2, 3, 1, 1, 0, 0);
    drive(1, 1, 1, 5, 1, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    id_valid = 0;
    at_neg();
    check("rst2_sel_a", sel_a, 0);
    check("rst2_sel_b", sel_b, 0);
    check("rst2_ex_valid", ex_valid, 0);
    check("rst2_cnt", scnt, 0);
    check("rst2_stall", stall, 0);

    // randomized traffic; a stalled instruction is re-presented
    for (int i = 0; i < 3000; i++) begin
      hold = exp_stall();
      @(posedge clk);
      #1;
      rst = ($urandom % 200) == 0;
      if (!hold) begin
        id_valid = ($urandom % 4) != 0;
        id_rs    = AW'($urandom_range(0, 3));
        id_rt    = AW'($urandom_range(0, 3));
        id_rd    = AW'($urandom_range(0, 3));
        id_rw    = ($urandom % 4) != 0;
        id_mr    = ($urandom % 3) == 0;
        flush    = ($urandom % 16) == 0;
      end
    end

    // counter saturation: a self-dependent load stalls every other cycle
    do_reset();
    id_valid = 1; id_rs = AW'(4); id_rt = AW'(4); id_rd = AW'(4);
    id_rw = 1; id_mr = 1; flush = 0;
    repeat (2 * (CMAX + 1 + 3) + 4) @(posedge clk);
    at_neg();
    check("sat_cnt", scnt, CMAX);
    @(posedge clk);
    at_neg();
    check("sat_cnt_hold", scnt, CMAX);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
